// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default constants for the aging priority arbiter
//
// Purpose : FSM state encoding and default parameter values used by the
//           arbiter top, its interface and the per-source aging counter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_PRIO_W     = 3;
  localparam int DEF_AGE_THRESH = 8;

endpackage

// File: rtl/aging_priority_arbiter_if.sv
// rtl/aging_priority_arbiter_if.sv - request/grant bundle between requesters and the arbiter
//
// Purpose : groups the request side (req, prios, done) and the grant side
//           (gnt, gnt_id, valid) of the arbiter.
// Signals : req    [NUM_REQ]         level request per source
//           prios  [NUM_REQ*PRIO_W]  static priority, source i at [i*PRIO_W +: PRIO_W]
//           done                     granted source releases the resource
//           gnt    [NUM_REQ]         registered one-hot grant
//           gnt_id [clog2(NUM_REQ)]  index of granted source, 0 when idle
//           valid                    |gnt
// Modports: master = requester side, slave = arbiter side.
interface aging_priority_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PRIO_W  = DEF_PRIO_W
);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*PRIO_W-1:0]  prios;
  logic                       done;
  logic [NUM_REQ-1:0]         gnt;
  logic [$clog2(NUM_REQ)-1:0] gnt_id;
  logic                       valid;

  modport master (
    output req, prios, done,
    input  gnt, gnt_id, valid
  );

  modport slave (
    input  req, prios, done,
    output gnt, gnt_id, valid
  );

endinterface

// File: rtl/arb_age_counter.sv
// rtl/arb_age_counter.sv - per-source wait counter and saturating priority boost
//
// Purpose : counts cycles a source waits with its request up; every
//           AGE_THRESH waiting cycles the boost steps up by one, saturating
//           at all-ones. Both clear while the source is not requesting or
//           while it is being / has been granted.
// Ports   : clk, rst   clock, async active-high reset
//           req        this source's request
//           clr        source is granted this cycle or currently holds the grant
//           boost      added to the source's static priority
module arb_age_counter
  import arb_pkg::*;
#(
  parameter int PRIO_W     = DEF_PRIO_W,
  parameter int AGE_THRESH = DEF_AGE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              clr,
  output logic [PRIO_W-1:0] boost
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AGE_THRESH - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      boost <= '0;
    end else if (!req || clr) begin
      cnt   <= '0;
      boost <= '0;
    end else if (cnt == CNT_LAST) begin
      // AGE_THRESH-th waiting cycle: restart the count and step the boost
      cnt <= '0;
      if (boost != '1) begin
        boost <= boost + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aging_priority_arbiter.sv
// rtl/aging_priority_arbiter.sv - priority arbiter with round-robin ties and optional aging
//
// Purpose : grants one requester at a time to a shared resource. Winner is
//           the requester with the highest effective priority (static prio
//           plus aging boost); ties resolve round-robin after the last grant.
//           A grant is held until done or until the granted request drops,
//           and at least one idle cycle separates consecutive grants.
// Ports   : clk   clock, all state on the rising edge
//           rst   asynchronous active-high reset
//           bus   aging_priority_arbiter_if.slave (req, prios, done in;
//                 gnt, gnt_id, valid out, all registered)
// Config  : define ARB_AGING_EN to build the per-source wait counters and
//           boosts; without it the effective priority is the static priority.
module aging_priority_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int PRIO_W     = DEF_PRIO_W,
  parameter int AGE_THRESH = DEF_AGE_THRESH
) (
  input logic                     clk,
  input logic                     rst,
  aging_priority_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int EFF_W = PRIO_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || AGE_THRESH < 1 || AGE_THRESH > 255 || PRIO_W < 1) begin : g_bad_cfg
    $error("aging_priority_arbiter: parameter out of range");
  end

  arb_state_e         state;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic               valid_q;
  logic [ID_W-1:0]    last_gnt;

  logic [EFF_W-1:0]   eff [NUM_REQ];
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [EFF_W-1:0]   best_eff;
  logic [ID_W-1:0]    scan_idx;

`ifdef ARB_AGING_EN
  logic [PRIO_W-1:0]  boost [NUM_REQ];
  logic [NUM_REQ-1:0] grant_now;

  // one-hot of the source being granted at this edge
  assign grant_now = (state == IDLE && win_found) ? (NUM_REQ'(1) << win_id) : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
    arb_age_counter #(
      .PRIO_W     (PRIO_W),
      .AGE_THRESH (AGE_THRESH)
    ) u_age (
      .clk   (clk),
      .rst   (rst),
      .req   (bus.req[i]),
      .clr   (grant_now[i] | gnt_q[i]),
      .boost (boost[i])
    );
    assign eff[i] = {1'b0, bus.prios[i*PRIO_W +: PRIO_W]} + {1'b0, boost[i]};
  end
`else
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_eff
    assign eff[i] = {1'b0, bus.prios[i*PRIO_W +: PRIO_W]};
  end
`endif

  // Scan from last_gnt+1 with wrap; only a strictly higher priority replaces
  // the current candidate, so the first tied requester in scan order wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    best_eff  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last_gnt) + 1 + k) % NUM_REQ);
      if (bus.req[scan_idx] && (!win_found || eff[scan_idx] > best_eff)) begin
        win_found = 1'b1;
        win_id    = scan_idx;
        best_eff  = eff[scan_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      valid_q  <= 1'b0;
      last_gnt <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          // done is meaningless without a grant and is not looked at here
          if (win_found) begin
            state    <= BUSY;
            gnt_q    <= NUM_REQ'(1) << win_id;
            gnt_id_q <= win_id;
            valid_q  <= 1'b1;
            last_gnt <= win_id;
          end
        end
        BUSY: begin
          // release goes to IDLE, so the next grant is at least one cycle later
          if (bus.done || !bus.req[gnt_id_q]) begin
            state    <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.valid  = valid_q;

endmodule

// File: doc/aging_priority_arbiter.md
AGING_PRIORITY_ARBITER -- requirements
Module: aging_priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter PRIO_W, default 3: per-requester priority width.
REQ-003 SHALL have parameter AGE_THRESH, default 8: waiting cycles per aging boost step (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ  request per source, level-held until served.
REQ-007 SHALL have port prios  input  NUM_REQ*PRIO_W  static priority; source i = prios[i*PRIO_W +: PRIO_W]; higher value wins.
REQ-008 SHALL have port done  input  1  granted source releases the shared resource.
REQ-009 SHALL have port gnt  output  NUM_REQ  registered one-hot grant.
REQ-010 SHALL have port gnt_id  output  clog2(NUM_REQ)  index of granted source; 0 when idle.
REQ-011 SHALL have port valid  output  1  equals |gnt.

Function
REQ-012 SHALL implement two states: IDLE (no grant) and BUSY (grant held).
REQ-013 In IDLE with req!=0, SHALL select a winner and enter BUSY; gnt/gnt_id/valid assert on the next clk edge (1-cycle latency).
REQ-014 Winner SHALL be the requesting source with the highest effective priority, eff_i = prio_i + boost_i, computed in PRIO_W+1 bits (no overflow).
REQ-015 Ties SHALL be broken round-robin: scan starts at last_gnt+1, wraps at NUM_REQ-1 to 0; first tied requester wins.
REQ-016 last_gnt SHALL update to the winner's index on every grant.
REQ-017 In BUSY, gnt SHALL stay constant until done=1 or req[gnt_id]=0; gnt then clears on the next edge and the FSM returns to IDLE.
REQ-018 Release and re-arbitration SHALL NOT share a cycle: minimum one idle cycle (valid=0) between consecutive grants.
REQ-019 req changes of non-granted sources during BUSY SHALL NOT affect gnt.
REQ-020 done asserted while IDLE SHALL be ignored.
REQ-021 Aging: each non-granted source with req=1 increments a wait counter per cycle; at AGE_THRESH the counter clears and boost_i increments, saturating at 2^PRIO_W-1.
REQ-022 A source's wait counter and boost SHALL clear on the cycle it is granted, and whenever its req=0.
REQ-023 gnt SHALL be one-hot or zero at all times.

Reset
REQ-024 rst=1 SHALL immediately force gnt=0, gnt_id=0, valid=0, FSM=IDLE, all counters and boosts=0, last_gnt=NUM_REQ-1 (source 0 wins first tie).
REQ-025 Reset asserted mid-grant SHALL drop the grant without waiting for done; first arbitration occurs on the first edge after rst deasserts.

Configuration
REQ-026 Macro ARB_AGING_EN SHALL compile in wait counters and boosts (REQ-021/022).
REQ-027 Without ARB_AGING_EN, eff_i SHALL equal prio_i, no counter logic SHALL exist, and all other behaviour is unchanged.

Structure
REQ-028 Package arb_pkg SHALL hold the FSM state enum (IDLE, BUSY) and default parameter constants.
REQ-029 Per-source aging SHALL be a sub-module arb_age_counter instantiated NUM_REQ times under ARB_AGING_EN.

Verification
REQ-030 rst=1 mid-grant (gnt=4'b0100) -> gnt=0, valid=0, gnt_id=0 before next clk edge.
REQ-031 req=4'b0011, p0=2, p1=5 -> next edge gnt=4'b0010, gnt_id=1; held 10 cycles until done=1; gnt=0 one edge later.
REQ-032 req=4'b0101, p0=p2=3, done pulsed per grant -> grant sequence 0,2,0,2 with one idle cycle between each.
REQ-033 Granted source 1 drops req with done=0 -> gnt=0 on next edge; FSM IDLE.
REQ-034 ARB_AGING_EN, AGE_THRESH=8: req0 prio 7 re-requesting continuously, req1 prio 4 held -> req1 granted within 4*8+8 cycles; its boost reads 0 after grant.
REQ-035 Without ARB_AGING_EN, same stimulus -> req1 never granted in 200 cycles.
